// File: rtl/pop_ui_pkg.sv
// Shared definitions for the POP front-panel button conditioner: repeat FSM
// states, button indices and default timing at 2.5 MHz.
package pop_ui_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam int unsigned NUM_BTN       = 4;
  localparam int unsigned BTN_PIE_PLUS  = 0;
  localparam int unsigned BTN_PIE_MINUS = 1;
  localparam int unsigned BTN_FP_PLUS   = 2;
  localparam int unsigned BTN_FP_MINUS  = 3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 25000;    // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 1250000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 250000;   // 100 ms
  localparam int unsigned DEF_CNT_W           = 21;

  // Opposing buttons of one adjust pair held together cancel each other.
  function automatic logic pair_conflict(input logic plus, input logic minus);
    return plus & minus;
  endfunction

endpackage

// File: rtl/pop_button_channel.sv
// One pushbutton: two-flop synchroniser, debounce filter and press-and-hold
// auto-repeat FSM producing a one-cycle raw_pulse per press/repeat.
module pop_button_channel
  import pop_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic        REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk_2M5,
  input  logic reset_n,
  input  logic btn_n,
  output logic held,
  output logic raw_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_ff;
  logic             sync;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_nxt;
  logic             held_nxt;
  logic [CNT_W-1:0] rpt_cnt;
  rpt_state_t       state;

  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[0], btn_n};
    end
  end

  assign sync = ~sync_ff[1];

  always_comb begin
    held_nxt = held;
    db_nxt   = '0;
    if (sync != held) begin
      if (db_cnt == DB_LAST) begin
        held_nxt = sync;
      end else begin
        db_nxt = db_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      held   <= 1'b0;
      db_cnt <= '0;
    end else begin
      held   <= held_nxt;
      db_cnt <= db_nxt;
    end
  end

  // The FSM follows held_nxt so raw_pulse registers on the same edge as held;
  // the top's output register then places the press strobe one cycle later.
  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RPT_IDLE;
      rpt_cnt   <= '0;
      raw_pulse <= 1'b0;
    end else begin
      raw_pulse <= 1'b0;
      if (!held_nxt) begin
        state   <= RPT_IDLE;
        rpt_cnt <= '0;
      end else begin
        case (state)
          RPT_IDLE: begin
            raw_pulse <= 1'b1;
            rpt_cnt   <= '0;
            state     <= RPT_DELAY;
          end
          RPT_DELAY: begin
            if (REPEAT_EN) begin
              if (rpt_cnt == DLY_LAST) begin
                raw_pulse <= 1'b1;
                rpt_cnt   <= '0;
                state     <= RPT_REPEAT;
              end else begin
                rpt_cnt <= rpt_cnt + CNT_W'(1);
              end
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt == PER_LAST) begin
              raw_pulse <= 1'b1;
              rpt_cnt   <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + CNT_W'(1);
            end
          end
          default: begin
            state   <= RPT_IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pop_button_conditioner.sv
// Four-button front-panel conditioner for the POP timer adjust inputs:
// per-button channels plus opposing-pair suppression and registered strobes.
module pop_button_conditioner
  import pop_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic        REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                 clk_2M5,
  input  logic                 reset_n,
  input  logic [NUM_BTN-1:0]   btn_n,
  output logic [NUM_BTN-1:0]   strobe,
  output logic [NUM_BTN-1:0]   held
);

  logic [NUM_BTN-1:0] raw_pulse;
  logic [NUM_BTN-1:0] mask;
  logic               pie_conflict;
  logic               fp_conflict;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    pop_button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk_2M5   (clk_2M5),
      .reset_n   (reset_n),
      .btn_n     (btn_n[g]),
      .held      (held[g]),
      .raw_pulse (raw_pulse[g])
    );
  end

  assign pie_conflict = pair_conflict(held[BTN_PIE_PLUS], held[BTN_PIE_MINUS]);
  assign fp_conflict  = pair_conflict(held[BTN_FP_PLUS], held[BTN_FP_MINUS]);

  // Masked pulses are dropped outright; the channel FSMs keep their timing.
  always_comb begin
    mask                = '0;
    mask[BTN_PIE_PLUS]  = pie_conflict;
    mask[BTN_PIE_MINUS] = pie_conflict;
    mask[BTN_FP_PLUS]   = fp_conflict;
    mask[BTN_FP_MINUS]  = fp_conflict;
  end

  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      strobe <= '0;
    end else begin
      strobe <= raw_pulse & ~mask;
    end
  end

endmodule
